// File: rtl/counter_ml_if.sv
// Bundles the counter_ml control, data and status signals; the parent drives the
// master side, the counter sits on the slave side.
interface counter_ml_if #(
  parameter int W = 10
);
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] term;
  logic         mode;
  logic         start;
  logic         dir;
  logic [W-1:0] q;
  logic         co;
  logic         busy;
  logic         done;

  modport master (
    output en, load, din, term, mode, start, dir,
    input  q, co, busy, done
  );

  modport slave (
    input  en, load, din, term, mode, start, dir,
    output q, co, busy, done
  );
endinterface

// File: rtl/counter_ml.sv
// counter_ml: loadable counter with runtime terminal value, cascade carry and a one-shot FSM.
// Down counting exists only when COUNTER_ML_DOWN_EN is defined; otherwise dir is ignored.
module counter_ml #(
  parameter int           W       = 10,
  parameter logic [W-1:0] RST_VAL = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rn,
  counter_ml_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg;
  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;
  logic         busy_reg;
  logic         done_reg;
  logic         tc;
  logic         ca;
  logic         step;
  logic [W-1:0] wrap_val;
  logic [W-1:0] q_stepped;

`ifdef COUNTER_ML_DOWN_EN
  logic down;
  assign down      = bus.dir;
  assign tc        = down ? (q_reg == '0) : (q_reg == bus.term);
  assign wrap_val  = down ? bus.term : '0;
  assign q_stepped = down ? (q_reg - 1'b1) : (q_reg + 1'b1);
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
  assign tc         = (q_reg == bus.term);
  assign wrap_val   = '0;
  assign q_stepped  = q_reg + 1'b1;
`endif

  // One-shot mode only counts while a run is in progress.
  assign ca   = ~bus.mode | (state_reg == RUN);
  assign step = bus.en & ca;
  // Gated by rn so a reset value that happens to match term cannot leak a carry.
  assign bus.co = rn & step & tc;

  always_comb begin
    q_next = q_reg;
    if (bus.load) begin
      q_next = bus.din;
    end else if (step) begin
      if (tc) begin
        if (!bus.mode) begin
          q_next = wrap_val;
        end
      end else begin
        q_next = q_stepped;
      end
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      q_reg <= RST_VAL;
    end else begin
      q_reg <= q_next;
    end
  end

  // busy/done are registered alongside the state so they equal "in RUN"/"in DONE".
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start & bus.mode) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
          done_reg <= 1'b0;
        end
        RUN: begin
          if (!bus.mode) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end else if (bus.co) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_counter_ml.sv
// Scoreboard bench for counter_ml (W=4): a driver pushes model predictions per cycle,
// a monitor pops and compares on the falling edge. Stage 1 is cascaded from stage 0's co.
module tb_counter_ml;
  localparam int W = 4;
`ifdef COUNTER_ML_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  counter_ml_if #(.W(W)) bus ();
  counter_ml_if #(.W(W)) cbus ();

  counter_ml #(.W(W)) dut (.clk(clk), .rn(rn), .bus(bus.slave));
  counter_ml #(.W(W)) dut1 (.clk(clk), .rn(rn), .bus(cbus.slave));

  assign cbus.en = bus.co;

  typedef struct {
    int cyc;
    int q;
    int q1;
    bit busy;
    bit done;
    bit co;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Behavioural model: counter values as integers mod 16, phase 0=idle 1=run 2=done.
  int m_q  = 15;
  int m_q1 = 15;
  int m_ph = 0;

  function automatic bit m_co();
    bit dn;
    bit tc;
    dn = DOWN_EN && bus.dir;
    tc = dn ? (m_q == 0) : (m_q == int'(bus.term));
    return rn && bus.en && (!bus.mode || m_ph == 1) && tc;
  endfunction

  task automatic push();
    exp_t e;
    e.cyc  = cyc_n;
    e.q    = m_q;
    e.q1   = m_q1;
    e.busy = (m_ph == 1);
    e.done = (m_ph == 2);
    e.co   = m_co();
    sb.push_back(e);
    cyc_n++;
  endtask

  task automatic model_reset();
    m_q  = 15;
    m_q1 = 15;
    m_ph = 0;
  endtask

  task automatic advance();
    bit co;
    bit dn;
    int nq;
    int nph;
    if (!rn) begin
      model_reset();
    end else begin
      co = m_co();
      dn = DOWN_EN && bus.dir;
      nq = m_q;
      if (bus.load) begin
        nq = int'(bus.din);
      end else if (bus.en && (!bus.mode || m_ph == 1)) begin
        if (co) nq = bus.mode ? m_q : (dn ? int'(bus.term) : 0);
        else    nq = dn ? (m_q + 15) % 16 : (m_q + 1) % 16;
      end
      nph = m_ph;
      if (m_ph == 0 && bus.start && bus.mode) nph = 1;
      else if (m_ph == 1 && !bus.mode)        nph = 0;
      else if (m_ph == 1 && co)               nph = 2;
      else if (m_ph == 2)                     nph = 0;
      if (cbus.load)  m_q1 = int'(cbus.din);
      else if (co)    m_q1 = (m_q1 == 9) ? 0 : (m_q1 + 1) % 16;
      m_q  = nq;
      m_ph = nph;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      push();
      @(posedge clk);
      advance();
      #2;
    end
  endtask

  task automatic set_in(input bit en, input bit load, input int din, input int term,
                        input bit mode, input bit start, input bit dir);
    bus.en    = en;
    bus.load  = load;
    bus.din   = W'(din);
    bus.term  = W'(term);
    bus.mode  = mode;
    bus.start = start;
    bus.dir   = dir;
  endtask

  task automatic pulse_reset();
    #1;
    rn = 1'b0;
    model_reset();
    push();
    @(posedge clk);
    advance();
    #2;
    rn = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp, input int c);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  // Monitor: one transaction per falling edge whenever a prediction is waiting.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("cyc %0d q=%0d q1=%0d busy=%0b done=%0b co=%0b", e.cyc, bus.q, cbus.q,
                 bus.busy, bus.done, bus.co);
        chk("q",    int'(bus.q),    e.q,    e.cyc);
        chk("q1",   int'(cbus.q),   e.q1,   e.cyc);
        chk("busy", int'(bus.busy), int'(e.busy), e.cyc);
        chk("done", int'(bus.done), int'(e.done), e.cyc);
        chk("co",   int'(bus.co),   int'(e.co),   e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cbus.load  = 1'b0;
    cbus.din   = '0;
    cbus.term  = 4'd9;
    cbus.mode  = 1'b0;
    cbus.start = 1'b0;
    cbus.dir   = 1'b0;
    // Reset with q==term so the forced-low co is exercised.
    set_in(1, 0, 0, 15, 0, 0, 0);
    rn = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    cyc(2);
    rn = 1'b1;

    // Free-run wrap at term=5.
    set_in(1, 0, 0, 5, 0, 0, 0);
    cyc(10);

    // One-shot from 2 to 4.
    set_in(0, 1, 2, 4, 1, 0, 0);
    cyc(1);
    set_in(1, 0, 0, 4, 1, 1, 0);
    cyc(1);
    set_in(1, 0, 0, 4, 1, 0, 0);
    cyc(7);

    // Start with q above term: full wrap before terminal.
    set_in(0, 1, 14, 3, 0, 0, 0);
    cyc(1);
    set_in(1, 0, 0, 3, 0, 0, 0);
    cyc(7);

    // Simultaneous start and load, then asynchronous reset mid-run.
    set_in(1, 1, 0, 9, 1, 1, 0);
    cyc(1);
    set_in(1, 0, 0, 9, 1, 0, 0);
    cyc(3);
    pulse_reset();
    cyc(3);

    // Direction request; counts down only with the down build.
    set_in(0, 1, 1, 3, 0, 0, 1);
    cyc(1);
    set_in(1, 0, 0, 3, 0, 0, 1);
    cyc(6);

    // Mode drop mid-run aborts without done.
    set_in(1, 1, 0, 12, 1, 1, 0);
    cyc(1);
    set_in(1, 0, 0, 12, 1, 0, 0);
    cyc(2);
    set_in(1, 0, 0, 12, 0, 0, 0);
    cyc(2);

    // Cascaded decade pair from 00.
    set_in(0, 1, 0, 9, 0, 0, 0);
    cbus.load = 1'b1;
    cyc(1);
    cbus.load = 1'b0;
    set_in(1, 0, 0, 9, 0, 0, 0);
    cyc(105);

    // Randomized traffic.
    begin
      int term_v;
      bit mode_v;
      term_v = 9;
      mode_v = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(7) == 0) term_v = $urandom_range(15);
        if ($urandom_range(19) == 0) mode_v = ~mode_v;
        set_in($urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(15),
               term_v, mode_v, $urandom_range(3) == 0, $urandom_range(1) == 1);
        cbus.load = ($urandom_range(49) == 0);
        cbus.din  = W'($urandom_range(15));
        if ($urandom_range(149) == 0) pulse_reset();
        else cyc(1);
      end
      cbus.load = 1'b0;
    end

    set_in(0, 0, 0, 9, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0, cyc_n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
